// File: rtl/nmr_sweep_pkg.sv
// Shared types and default widths for the NMR T1 parameter sweep master.
package nmr_sweep_pkg;

    localparam int DATA_W_DEFAULT   = 32;
    localparam int ADDR_W_DEFAULT   = 2;
    localparam int CNT_W_DEFAULT    = 16;
    localparam int REG_ADDR_DEFAULT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_ARM,
        ST_WAIT_ACQ,
        ST_DONE
    } sweep_state_t;

endpackage

// File: rtl/nmr_sweep_accum.sv
// Sweep value accumulator: holds cur_t1, adds the step on request and keeps
// a sticky flag for any addition that carried out of DATA_W bits.
module nmr_sweep_accum
    import nmr_sweep_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              step_en,
    input  logic [DATA_W-1:0] step_val,
    output logic [DATA_W-1:0] value,
    output logic              ovf
);

    logic [DATA_W-1:0] value_q, value_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W:0]   sum;

    always_comb begin
        sum     = {1'b0, value_q} + {1'b0, step_val};
        value_d = value_q;
        ovf_d   = ovf_q;
        if (load) begin
            value_d = load_val;
            ovf_d   = 1'b0;
        end else if (step_en) begin
            value_d = sum[DATA_W-1:0];
            ovf_d   = ovf_q | sum[DATA_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value = value_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/nmr_t1_sweep_master.sv
// Avalon-MM master sweeping an NMR parameter PIO register over n_steps
// acquisitions. Define T1_READBACK_EN to verify each write by reading it back.
//
// state    | meaning
// IDLE     | waiting for start
// WRITE    | Avalon write of cur_t1 in progress
// READ     | readback of the written value (T1_READBACK_EN only)
// ARM      | one-cycle sequencer trigger
// WAIT_ACQ | waiting for acq_done
// DONE     | one-cycle done pulse, back to IDLE
module nmr_t1_sweep_master
    import nmr_sweep_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int REG_ADDR = REG_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] t1_start,
    input  logic [DATA_W-1:0] t1_step,
    input  logic [CNT_W-1:0]  n_steps,
    input  logic              acq_done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_read,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic              seq_trigger,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  step_idx,
    output logic [DATA_W-1:0] cur_t1,
    output logic              ovf,
    output logic              err
);

`ifdef T1_READBACK_EN
    localparam sweep_state_t AFTER_WRITE = ST_READ;
`else
    localparam sweep_state_t AFTER_WRITE = ST_ARM;
`endif

    sweep_state_t      state_q, state_d;
    logic [CNT_W-1:0]  step_idx_q, step_idx_d;
    logic [CNT_W-1:0]  n_steps_q, n_steps_d;
    logic [DATA_W-1:0] t1_step_q, t1_step_d;
    logic              err_q, err_d;
    logic              acc_load, acc_step;

    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        n_steps_d  = n_steps_q;
        t1_step_d  = t1_step_q;
        err_d      = err_q;
        acc_load   = 1'b0;
        acc_step   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_steps_d  = n_steps;
                    t1_step_d  = t1_step;
                    step_idx_d = '0;
                    err_d      = 1'b0;
                    acc_load   = 1'b1;
                    state_d    = (n_steps == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The request is held until accepted; abort only acts afterwards.
                if (!avm_waitrequest) state_d = abort ? ST_DONE : AFTER_WRITE;
            end
`ifdef T1_READBACK_EN
            ST_READ: begin
                if (!avm_waitrequest) begin
                    if (avm_readdata != cur_t1) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = abort ? ST_DONE : ST_ARM;
                    end
                end
            end
`endif
            ST_ARM: state_d = abort ? ST_DONE : ST_WAIT_ACQ;
            ST_WAIT_ACQ: begin
                // abort outranks a coincident acq_done: that step is not counted.
                if (abort) begin
                    state_d = ST_DONE;
                end else if (acq_done) begin
                    acc_step   = 1'b1;
                    step_idx_d = step_idx_q + CNT_W'(1);
                    state_d    = (step_idx_d == n_steps_q) ? ST_DONE : ST_WRITE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            step_idx_q <= '0;
            n_steps_q  <= '0;
            t1_step_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            n_steps_q  <= n_steps_d;
            t1_step_q  <= t1_step_d;
            err_q      <= err_d;
        end
    end

    nmr_sweep_accum #(.DATA_W(DATA_W)) u_accum (
        .clk      (clk),
        .reset    (reset),
        .load     (acc_load),
        .load_val (t1_start),
        .step_en  (acc_step),
        .step_val (t1_step_q),
        .value    (cur_t1),
        .ovf      (ovf)
    );

    assign avm_address   = ADDR_W'(REG_ADDR);
    assign avm_write     = (state_q == ST_WRITE);
    assign avm_writedata = cur_t1;
    assign seq_trigger   = (state_q == ST_ARM) && !abort;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign step_idx      = step_idx_q;
    assign err           = err_q;

`ifdef T1_READBACK_EN
    assign avm_read = (state_q == ST_READ);
`else
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata;
    assign avm_read        = 1'b0;
`endif

endmodule

// File: tb/tb_nmr_t1_sweep_master.sv
// Bench for nmr_t1_sweep_master: directed and random sweeps against an
// arithmetic model, with a PIO slave, stall driver and acquisition responder.
module tb_nmr_t1_sweep_master;

    localparam int DW = 32;
    localparam int AW = 2;
    localparam int CW = 16;
`ifdef T1_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          acq_done = 1'b0;
    logic          avm_waitrequest = 1'b0;
    logic [DW-1:0] t1_start = '0;
    logic [DW-1:0] t1_step = '0;
    logic [CW-1:0] n_steps = '0;
    logic [AW-1:0] avm_address;
    logic          avm_write, avm_read, seq_trigger, busy, done, ovf, err;
    logic [DW-1:0] avm_writedata, avm_readdata, cur_t1;
    logic [CW-1:0] step_idx;

    always #5 clk = ~clk;

    nmr_t1_sweep_master dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .t1_start        (t1_start),
        .t1_step         (t1_step),
        .n_steps         (n_steps),
        .acq_done        (acq_done),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .seq_trigger     (seq_trigger),
        .busy            (busy),
        .done            (done),
        .step_idx        (step_idx),
        .cur_t1          (cur_t1),
        .ovf             (ovf),
        .err             (err)
    );

    int n_err = 0;
    int n_checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave data register
    logic [DW-1:0] mem = '0;
    bit            rd_force = 1'b0;
    assign avm_readdata = rd_force ? 32'hDEAD_BEEF : mem;

    logic [DW-1:0] wr_log[$];
    int trig_cnt, done_cnt, busy_cnt, read_cnt, read_total, wr_cycles, stall_viol, done_cyc, start_cyc;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_wd = '0;

    initial forever begin
        @(negedge clk);
        if (prev_stall && (!avm_write || avm_writedata !== prev_wd)) stall_viol++;
        prev_stall = avm_write && avm_waitrequest;
        prev_wd    = avm_writedata;
        if (avm_write) begin
            wr_cycles++;
            if (!avm_waitrequest) begin
                wr_log.push_back(avm_writedata);
                mem = avm_writedata;
            end
        end
        if (avm_read && !avm_waitrequest) begin
            read_cnt++;
            read_total++;
        end
        if (seq_trigger) trig_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end

    int stall_budget = 0;
    bit stall_rand = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if ((avm_write || avm_read) && stall_budget > 0) begin
            avm_waitrequest = 1'b1;
            stall_budget--;
        end else if ((avm_write || avm_read) && stall_rand) begin
            avm_waitrequest = 1'($urandom_range(0, 1));
        end else begin
            avm_waitrequest = 1'b0;
        end
    end

    int acq_delay = 5;
    int abort_at = 0;
    int acq_num = 0;
    initial forever begin
        @(negedge clk);
        if (seq_trigger) begin
            repeat (acq_delay) @(posedge clk);
            #1;
            acq_num++;
            acq_done = 1'b1;
            if (acq_num == abort_at) abort = 1'b1;
            @(posedge clk);
            #1;
            acq_done = 1'b0;
            abort    = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_sweep(input logic [DW-1:0] s, input logic [DW-1:0] st, input int n);
        wr_log.delete();
        trig_cnt = 0; done_cnt = 0; busy_cnt = 0; read_cnt = 0;
        wr_cycles = 0; stall_viol = 0; acq_num = 0;
        @(posedge clk);
        #1;
        t1_start = s;
        t1_step  = st;
        n_steps  = CW'(n);
        start    = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start   = 1'b0;
        t1_start = $urandom;
        t1_step  = $urandom;
        n_steps  = CW'($urandom);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    // Expected sweep: writes s + i*st, final value s + n_acq*st, ovf iff the
    // true sum exceeds DW bits.
    task automatic check_model(input string tag, input logic [DW-1:0] s, input logic [DW-1:0] st,
                               input int n_wr, input int n_trig, input int n_acq);
        logic [63:0] wide;
        chk({tag, ".writes"}, 64'(wr_log.size()), 64'(n_wr));
        for (int i = 0; i < n_wr && i < wr_log.size(); i++)
            chk({tag, ".wdata"}, 64'(wr_log[i]), 64'(DW'(s + DW'(i) * st)));
        wide = 64'(s) + 64'(n_acq) * 64'(st);
        chk({tag, ".triggers"}, 64'(trig_cnt), 64'(n_trig));
        chk({tag, ".done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, ".cur_t1"}, 64'(cur_t1), {32'd0, wide[31:0]});
        chk({tag, ".step_idx"}, 64'(step_idx), 64'(n_acq));
        chk({tag, ".ovf"}, 64'(ovf), 64'(wide[63:32] != 0));
        chk({tag, ".stall_hold"}, 64'(stall_viol), 64'd0);
        chk({tag, ".busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        read_total = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.avm_write", 64'(avm_write), 64'd0);
        chk("rst.avm_read", 64'(avm_read), 64'd0);
        chk("rst.avm_address", 64'(avm_address), 64'd0);
        chk("rst.seq_trigger", 64'(seq_trigger), 64'd0);
        chk("rst.busy_done", 64'({busy, done}), 64'd0);
        chk("rst.cur_t1", 64'(cur_t1), 64'd0);
        chk("rst.step_idx", 64'(step_idx), 64'd0);
        chk("rst.ovf_err", 64'({ovf, err}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // abort while idle does nothing
        busy_cnt = 0;
        abort = 1'b1;
        repeat (3) @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("idle_abort.busy", 64'(busy_cnt), 64'd0);

        // basic three-step sweep
        do_sweep(32'd100, 32'd50, 3);
        check_model("basic", 32'd100, 32'd50, 3, 3, 3);
        chk("basic.busy_cycles", 64'(busy_cnt), 64'(3 * (7 + RB) + 1));
        chk("basic.err", 64'(err), 64'd0);

        // zero steps
        do_sweep(32'd77, 32'd3, 0);
        check_model("zero", 32'd77, 32'd3, 0, 0, 0);
        chk("zero.done_latency", 64'(done_cyc - start_cyc), 64'd1);
        chk("zero.busy_cycles", 64'(busy_cnt), 64'd1);

        // first write stalled for four cycles
        stall_budget = 4;
        do_sweep(32'h1234, 32'd1, 1);
        check_model("stall", 32'h1234, 32'd1, 1, 1, 1);
        chk("stall.write_cycles", 64'(wr_cycles), 64'd5);

        // wrap-around sets ovf
        do_sweep(32'hFFFF_FFF0, 32'h20, 2);
        check_model("wrap", 32'hFFFF_FFF0, 32'h20, 2, 2, 2);

        // abort coincident with the second acq_done
        abort_at = 2;
        do_sweep(32'd100, 32'd50, 3);
        abort_at = 0;
        check_model("abort", 32'd100, 32'd50, 2, 2, 1);

`ifdef T1_READBACK_EN
        rd_force = 1'b1;
        do_sweep(32'd5, 32'd1, 2);
        rd_force = 1'b0;
        chk("rb.err", 64'(err), 64'd1);
        chk("rb.triggers", 64'(trig_cnt), 64'd0);
        chk("rb.writes", 64'(wr_log.size()), 64'd1);
        chk("rb.reads", 64'(read_cnt), 64'd1);
        chk("rb.done_cnt", 64'(done_cnt), 64'd1);
`else
        chk("norb.reads", 64'(read_total), 64'd0);
        chk("norb.err", 64'(err), 64'd0);
`endif

        // random sweeps with random stalls and acquisition latency
        stall_rand = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [DW-1:0] s, st;
            int n;
            s  = $urandom;
            st = (k % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 1000));
            n  = $urandom_range(1, 5);
            acq_delay = $urandom_range(1, 6);
            do_sweep(s, st, n);
            check_model("rand", s, st, n, n, n);
            chk("rand.err", 64'(err), 64'd0);
        end
        stall_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
